loop_nest_seq: RTL and testbench

LOOP_NEST_SEQ -- requirements
Module: loop_nest_seq

---
 rtl/loop_nest_seq_if.sv | 34 +++
 rtl/loop_nest_seq.sv | 165 ++++++++++++++++
 tb/tb_loop_nest_seq.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_nest_seq_if.sv
// loop_nest_seq_if
// Groups the control, bound and tuple-stream signals of the loop-nest
// sequencer into one bundle.
//   master : the side that requests runs and consumes tuples
//            (drives start, clear, bounds, out_ready)
//   slave  : the sequencer itself
//            (drives idx, idx_valid, adv, first, last, busy, done)
// DEPTH and W must match the parameters of the attached sequencer.
interface loop_nest_seq_if #(
  parameter int DEPTH = 3,
  parameter int W     = 32
);
  logic                 start;
  logic                 clear;
  logic [DEPTH*W-1:0]   bounds;
  logic                 out_ready;
  logic [DEPTH*W-1:0]   idx;
  logic                 idx_valid;
  logic [DEPTH-2:0]     adv;
  logic                 first;
  logic                 last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, clear, bounds, out_ready,
    input  idx, idx_valid, adv, first, last, busy, done
  );

  modport slave (
    input  start, clear, bounds, out_ready,
    output idx, idx_valid, adv, first, last, busy, done
  );
endinterface

// File: rtl/loop_nest_seq.sv
// loop_nest_seq
// Walks a DEPTH-level loop nest in odometer order and streams each index
// tuple over a valid/ready handshake. Level 0 is the outermost loop, level
// DEPTH-1 the innermost; every packed vector puts level l at [l*W +: W].
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   bus.start  : begin a run with bus.bounds (only acted on while idle)
//   bus.clear  : synchronous abort back to idle, no done pulse
//   bus.bounds : per-level trip counts
//   bus.out_ready : consumer takes the current tuple
//   bus.idx / bus.idx_valid : current tuple and its valid flag
//   bus.adv    : adv[l] means the next tuple bumps level l and zeroes deeper levels
//   bus.first / bus.last : current tuple is the first / final one
//   bus.busy   : a run is in progress
//   bus.done   : one-cycle pulse after the final transfer or a zero-trip start
module loop_nest_seq #(
  parameter int DEPTH = 3,
  parameter int W     = 32
) (
  input logic              clk,
  input logic              reset,
  loop_nest_seq_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [DEPTH*W-1:0] idx_q, idx_n;
  logic [DEPTH*W-1:0] bounds_q, bounds_n;
  logic               done_q, done_n;

  logic               valid;
  logic [DEPTH-1:0]   at_max;
  logic [DEPTH-2:0]   deeper_max;
  logic               all_max;
  logic [DEPTH*W-1:0] idx_inc;
  logic               any_zero;
  logic [DEPTH-2:0]   adv;

  // A tuple is live for the whole of RUN, so valid and busy coincide.
  assign valid = (state == RUN);

  // Per-level "at bound-1" compare in W-bit arithmetic; idx never exceeds
  // bound-1, so a bound of 2^W-1 cannot overflow the index.
  always_comb begin
    at_max = '0;
    for (int l = 0; l < DEPTH; l++) begin
      at_max[l] = (idx_q[l*W +: W] == (bounds_q[l*W +: W] - W'(1)));
    end
  end

  // deeper_max[l] is set when every level deeper than l sits at bound-1;
  // folding in level 0 as well yields the "final tuple" condition.
  always_comb begin
    logic deep;
    deeper_max = '0;
    deep       = at_max[DEPTH-1];
    for (int l = DEPTH-2; l >= 0; l--) begin
      deeper_max[l] = deep;
      deep          = deep & at_max[l];
    end
    all_max = deep;
  end

  // Odometer increment: the innermost level always counts, and a level
  // already at bound-1 wraps to zero and passes the carry outward.
  always_comb begin
    logic carry;
    idx_inc = idx_q;
    carry   = 1'b1;
    for (int l = DEPTH-1; l >= 0; l--) begin
      if (carry) begin
        if (at_max[l]) begin
          idx_inc[l*W +: W] = '0;
        end else begin
          idx_inc[l*W +: W] = idx_q[l*W +: W] + W'(1);
          carry             = 1'b0;
        end
      end
    end
  end

  // A zero trip count anywhere means the nest body never executes.
  always_comb begin
    any_zero = 1'b0;
    for (int l = 0; l < DEPTH; l++) begin
      if (bus.bounds[l*W +: W] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  // Level l advances when all deeper levels wrap and l itself does not;
  // on the final tuple every level is at bound-1 so all bits drop out.
  always_comb begin
    adv = '0;
    for (int l = 0; l < DEPTH-1; l++) begin
      adv[l] = valid & deeper_max[l] & ~at_max[l];
    end
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = valid;
  assign bus.busy      = valid;
  assign bus.done      = done_q;
  assign bus.first     = valid & (idx_q == '0);
  assign bus.last      = valid & all_max;
  assign bus.adv       = adv;

  // Next-state logic. clear wins over everything; start is only looked at
  // while idle, so bounds stay frozen for the whole run.
  always_comb begin
    state_n  = state;
    idx_n    = idx_q;
    bounds_n = bounds_q;
    done_n   = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (any_zero) begin
              done_n = 1'b1;
            end else begin
              bounds_n = bus.bounds;
              idx_n    = '0;
              state_n  = RUN;
            end
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (all_max) begin
              state_n = IDLE;
              idx_n   = '0;
              done_n  = 1'b1;
            end else begin
              idx_n = idx_inc;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register; reset abandons any run without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx_q    <= '0;
      bounds_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx_q    <= idx_n;
      bounds_q <= bounds_n;
      done_q   <= done_n;
    end
  end

endmodule

// File: tb/tb_loop_nest_seq.sv
// tb_loop_nest_seq
// Self-checking bench for loop_nest_seq (DEPTH=3, W=8). Expected tuples are
// generated from the bounds by mixed-radix decomposition of a running count
// and queued when a run is started; a negedge monitor compares every live
// tuple against the queue head and pops it on each transfer.
module tb_loop_nest_seq;
  localparam int DEPTH = 3;
  localparam int W     = 8;

  typedef struct packed {
    logic [DEPTH*W-1:0] idx;
    logic               first;
    logic               last;
    logic [DEPTH-2:0]   adv;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   popped;
  bit   mon_en;
  exp_t sb[$];

  loop_nest_seq_if #(.DEPTH(DEPTH), .W(W)) bus ();

  loop_nest_seq #(.DEPTH(DEPTH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DEPTH*W-1:0] pack(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  // Queue every tuple of a (b0,b1,b2) run; adv marks the outermost level
  // that changes between tuple n and tuple n+1 (innermost changes give 0).
  task automatic push_expected(input int b0, input int b1, input int b2);
    int   prod;
    exp_t e;
    int   t0, t1, t2, n0, n1;
    prod = b0 * b1 * b2;
    for (int n = 0; n < prod; n++) begin
      t2 = n % b2;
      t1 = (n / b2) % b1;
      t0 = n / (b2 * b1);
      n1 = ((n + 1) / b2) % b1;
      n0 = (n + 1) / (b2 * b1);
      e.idx   = pack(t0, t1, t2);
      e.first = (n == 0);
      e.last  = (n == prod - 1);
      if (n == prod - 1)  e.adv = 2'b00;
      else if (n0 != t0)  e.adv = 2'b01;
      else if (n1 != t1)  e.adv = 2'b10;
      else                e.adv = 2'b00;
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: compares live tuples and the done/idx_valid exclusion.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (bus.done && bus.idx_valid) begin
        tests++;
        fails++;
        $display("[TB] FAIL done_valid_overlap: done=%0b idx_valid=%0b, required not both 1", bus.done, bus.idx_valid);
      end
      if (bus.idx_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb_underflow: idx=%h issued, no tuple expected", bus.idx);
        end else begin
          e = sb[0];
          if ({bus.idx, bus.first, bus.last, bus.adv} !== {e.idx, e.first, e.last, e.adv}) begin
            fails++;
            $display("[TB] FAIL tuple: got idx=%h first=%0b last=%0b adv=%b, want idx=%h first=%0b last=%0b adv=%b",
                     bus.idx, bus.first, bus.last, bus.adv, e.idx, e.first, e.last, e.adv);
          end
          if (bus.out_ready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [DEPTH*W-1:0] b);
    @(posedge clk);
    #1 bus.bounds = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.done) begin
        cycles = c;
        break;
      end
    end
  endtask

  // Full run with out_ready held high; checks latency to done and drain.
  task automatic run_case(input string name, input int b0, input int b1, input int b2);
    int cycles;
    int prod;
    prod = b0 * b1 * b2;
    bus.out_ready = 1'b1;
    popped = 0;
    push_expected(b0, b1, b2);
    do_start(pack(b0, b1, b2));
    wait_done(prod + 20, cycles);
    tests++;
    if (cycles !== prod) begin
      fails++;
      $display("[TB] FAIL %s_done_latency: done at cycle %0d, want %0d", name, cycles, prod);
    end
    tests++;
    if (popped !== prod || sb.size() !== 0) begin
      fails++;
      $display("[TB] FAIL %s_transfers: popped %0d left %0d, want %0d and 0", name, popped, sb.size(), prod);
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.idx_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_idle: busy=%0b idx_valid=%0b, want 0 0", name, bus.busy, bus.idx_valid);
    end
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_done_pulse: done=%0b one cycle later, want 0", name, bus.done);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({bus.idx, bus.idx_valid, bus.done, bus.busy, bus.adv, bus.first, bus.last} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: idx=%h v=%0b d=%0b b=%0b adv=%b f=%0b l=%0b, want all 0",
               bus.idx, bus.idx_valid, bus.done, bus.busy, bus.adv, bus.first, bus.last);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: busy=%0b done=%0b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    run_case("basic222", 2, 2, 2);
  endtask

  task automatic test_single();
    run_case("single111", 1, 1, 1);
  endtask

  task automatic test_max_bound();
    run_case("max_bound", 1, 1, 255);
  endtask

  task automatic test_zero_bound();
    bus.out_ready = 1'b1;
    do_start(pack(3, 0, 4));
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b1 || bus.idx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_bound_done: done=%0b idx_valid=%0b busy=%0b, want 1 0 0", bus.done, bus.idx_valid, bus.busy);
    end
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_bound_after: done=%0b busy=%0b, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_stall();
    bit got;
    got = 1'b0;
    popped = 0;
    bus.out_ready = 1'b0;
    push_expected(2, 3, 2);
    do_start(pack(2, 3, 2));
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b1;
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL stall_timeout: done=0 after 400 cycles, want done");
    end
    tests++;
    if (popped !== 12 || sb.size() !== 0) begin
      fails++;
      $display("[TB] FAIL stall_transfers: popped %0d left %0d, want 12 and 0", popped, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_abort();
    bit saw_done;
    saw_done = 1'b0;
    popped = 0;
    bus.out_ready = 1'b1;
    push_expected(2, 2, 2);
    do_start(pack(2, 2, 2));
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.bounds = pack(3, 3, 3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.idx_valid !== 1'b0 || bus.done !== 1'b0 || bus.idx !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_clear: idx_valid=%0b done=%0b idx=%h busy=%0b, want 0 0 0 0",
               bus.idx_valid, bus.done, bus.idx, bus.busy);
    end
    tests++;
    if (popped !== 5 || sb.size() !== 3) begin
      fails++;
      $display("[TB] FAIL abort_progress: popped %0d left %0d, want 5 and 3", popped, sb.size());
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_no_done: done seen=%0b, want 0", saw_done);
    end
    sb.delete();
    run_case("after_abort", 3, 1, 2);
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    saw_done = 1'b0;
    popped = 0;
    bus.out_ready = 1'b1;
    push_expected(2, 2, 2);
    do_start(pack(2, 2, 2));
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({bus.idx, bus.idx_valid, bus.done, bus.busy, bus.adv, bus.first, bus.last} !== '0) begin
      fails++;
      $display("[TB] FAIL midrun_reset_outputs: idx=%h v=%0b d=%0b b=%0b adv=%b f=%0b l=%0b, want all 0",
               bus.idx, bus.idx_valid, bus.done, bus.busy, bus.adv, bus.first, bus.last);
    end
    tests++;
    if (popped !== 3 || sb.size() !== 5) begin
      fails++;
      $display("[TB] FAIL midrun_progress: popped %0d left %0d, want 3 and 5", popped, sb.size());
    end
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_no_done: done seen=%0b after release, want 0", saw_done);
    end
    run_case("after_reset", 2, 1, 2);
  endtask

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    popped = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.bounds = '0;
    bus.out_ready = 1'b1;
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_single();
    test_zero_bound();
    test_stall();
    test_max_bound();
    test_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
